// File: rtl/rs_pkg.sv
// Shared defaults, state encodings and counter widths for the RS syndrome front end.
package rs_pkg;
  localparam int RS_N      = 255;
  localparam int RS_K      = 239;
  localparam int RS_T      = 8;
  localparam int RS_M      = 8;
  localparam int RS_STAT_W = 16;
  localparam int RS_CNT_W  = $clog2(RS_N + 1);
  localparam int RS_SIDX_W = $clog2(2 * RS_T + 1);

  typedef enum logic {IDLE, RUN} ing_state_e;
  typedef enum logic [1:0] {WAIT, CAPTURE, DECIDE, REPLAY} col_state_e;
endpackage

// File: rtl/rs_synd_collector.sv
// Captures the 2t serial syndromes, zero-detects them, replays them to the KES.
// Optional frame statistics are built only when RS_FRAME_STATS_EN is defined.
module rs_synd_collector
  import rs_pkg::*;
#(
  parameter int T      = RS_T,
  parameter int M      = RS_M,
  parameter int STAT_W = RS_STAT_W
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [M-1:0]      syndrome_in,
  input  logic              scalc_done_in,
  input  logic              kes_ready_in,
  output logic [M-1:0]      synd_out,
  output logic              synd_valid_out,
  output logic              frame_clean_out,
  output logic              kes_start_out,
  output logic              overrun_out,
  output logic [STAT_W-1:0] stat_total_out,
  output logic [STAT_W-1:0] stat_err_out
);
  localparam int NS = 2 * T;
  localparam int SW = $clog2(NS + 1);
  localparam int IW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [SW-1:0] LAST = SW'(NS - 1);

  col_state_e          state, state_nx;
  logic [SW-1:0]       idx, idx_nx;
  logic                nz, nz_nx;
  logic                cap_en, set_ovr;
  logic [NS-1:0][M-1:0] sbuf;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state       <= WAIT;
      idx         <= '0;
      nz          <= 1'b0;
      overrun_out <= 1'b0;
      sbuf        <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      nz    <= nz_nx;
      if (cap_en)  sbuf[idx[IW-1:0]] <= syndrome_in;
      if (set_ovr) overrun_out <= 1'b1;
    end
  end

  // Decision and first replay beat share the cycle after the last capture,
  // so KES start coincides with S1 on synd_out.
  always_comb begin
    state_nx        = state;
    idx_nx          = idx;
    nz_nx           = nz;
    cap_en          = 1'b0;
    set_ovr         = 1'b0;
    synd_out        = '0;
    synd_valid_out  = 1'b0;
    frame_clean_out = 1'b0;
    kes_start_out   = 1'b0;
    case (state)
      WAIT: begin
        if (scalc_done_in) begin
          cap_en   = 1'b1;
          nz_nx    = |syndrome_in;
          idx_nx   = SW'(1);
          state_nx = CAPTURE;
        end
      end
      CAPTURE: begin
        cap_en = 1'b1;
        nz_nx  = nz | (|syndrome_in);
        if (idx == LAST) begin
          idx_nx   = '0;
          state_nx = DECIDE;
        end else begin
          idx_nx = idx + 1'b1;
        end
      end
      DECIDE: begin
        state_nx = WAIT;
        if (!nz) begin
          frame_clean_out = 1'b1;
        end else if (kes_ready_in) begin
          kes_start_out  = 1'b1;
          synd_valid_out = 1'b1;
          synd_out       = sbuf[0];
          idx_nx         = SW'(1);
          state_nx       = REPLAY;
        end else begin
          set_ovr = 1'b1;
        end
      end
      REPLAY: begin
        synd_valid_out = 1'b1;
        synd_out       = sbuf[idx[IW-1:0]];
        if (idx == LAST) begin
          idx_nx   = '0;
          state_nx = WAIT;
        end else begin
          idx_nx = idx + 1'b1;
        end
      end
      default: state_nx = WAIT;
    endcase
  end

`ifdef RS_FRAME_STATS_EN
  logic decide;
  logic [STAT_W-1:0] tot_q, err_q;
  assign decide = (state == DECIDE);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      tot_q <= '0;
      err_q <= '0;
    end else if (decide) begin
      if (~&tot_q)       tot_q <= tot_q + 1'b1;
      if (nz && ~&err_q) err_q <= err_q + 1'b1;
    end
  end

  assign stat_total_out = tot_q;
  assign stat_err_out   = err_q;
`else
  assign stat_total_out = '0;
  assign stat_err_out   = '0;
`endif
endmodule

// File: rtl/rs_syndrome_ctrl.sv
// Frame sequencer ahead of SyndromeCalc: ingress FSM, 2-stage data alignment,
// syndrome collection and KES hand-off. Optional stats via RS_FRAME_STATS_EN.
module rs_syndrome_ctrl
  import rs_pkg::*;
#(
  parameter int N      = RS_N,
  parameter int T      = RS_T,
  parameter int M      = RS_M,
  parameter int STAT_W = RS_STAT_W
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [M-1:0]      data_in,
  input  logic              valid_in,
  input  logic              sof_in,
  output logic              sync_out,
  output logic [M-1:0]      sc_data_out,
  input  logic [M-1:0]      Syndrome_in,
  input  logic              Scalc_done_in,
  output logic [M-1:0]      synd_out,
  output logic              synd_valid_out,
  output logic              frame_clean_out,
  output logic              kes_start_out,
  input  logic              kes_ready_in,
  output logic              abort_out,
  output logic              overrun_out,
  output logic [STAT_W-1:0] stat_total_out,
  output logic [STAT_W-1:0] stat_err_out
);
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N);

  ing_state_e       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             sync_nx, abort_nx;
  logic [M-1:0]     d1;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state       <= IDLE;
      cnt         <= '0;
      sync_out    <= 1'b1;
      abort_out   <= 1'b0;
      d1          <= '0;
      sc_data_out <= '0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      sync_out    <= sync_nx;
      abort_out   <= abort_nx;
      d1          <= data_in;
      sc_data_out <= d1;
    end
  end

  // A sof landing exactly after symbol n chains frames without raising sync;
  // any gap or early sof mid-frame drops the frame by forcing sync high.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    sync_nx  = sync_out;
    abort_nx = 1'b0;
    case (state)
      IDLE: begin
        sync_nx = 1'b1;
        if (valid_in && sof_in) begin
          state_nx = RUN;
          cnt_nx   = CNT_W'(1);
          sync_nx  = 1'b0;
        end
      end
      RUN: begin
        if (cnt == CNT_LAST) begin
          if (valid_in && sof_in) begin
            cnt_nx  = CNT_W'(1);
            sync_nx = 1'b0;
          end else begin
            state_nx = IDLE;
            sync_nx  = 1'b1;
          end
        end else if (!valid_in || sof_in) begin
          abort_nx = 1'b1;
          state_nx = IDLE;
          sync_nx  = 1'b1;
        end else begin
          cnt_nx  = cnt + 1'b1;
          sync_nx = 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  rs_synd_collector #(.T(T), .M(M), .STAT_W(STAT_W)) u_coll (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .syndrome_in     (Syndrome_in),
    .scalc_done_in   (Scalc_done_in),
    .kes_ready_in    (kes_ready_in),
    .synd_out        (synd_out),
    .synd_valid_out  (synd_valid_out),
    .frame_clean_out (frame_clean_out),
    .kes_start_out   (kes_start_out),
    .overrun_out     (overrun_out),
    .stat_total_out  (stat_total_out),
    .stat_err_out    (stat_err_out)
  );
endmodule

// File: tb/tb_rs_syndrome_ctrl.sv
// Bench for rs_syndrome_ctrl: GF(2^8) SyndromeCalc stand-in plus a frame-level
// reference computing syndromes from the transmitted symbols.
module tb_rs_syndrome_ctrl;
  localparam int N  = 255;
  localparam int NS = 16;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [7:0]  data_in = 8'h00;
  logic        valid_in = 1'b0, sof_in = 1'b0;
  logic        sync_out;
  logic [7:0]  sc_data_out;
  logic [7:0]  Syndrome_in = 8'h00;
  logic        Scalc_done_in = 1'b0;
  logic [7:0]  synd_out;
  logic        synd_valid_out, frame_clean_out, kes_start_out;
  logic        kes_ready_in = 1'b1;
  logic        abort_out, overrun_out;
  logic [15:0] stat_total_out, stat_err_out;

  always #4 clk_in = ~clk_in;

  rs_syndrome_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in), .data_in(data_in), .valid_in(valid_in),
    .sof_in(sof_in), .sync_out(sync_out), .sc_data_out(sc_data_out),
    .Syndrome_in(Syndrome_in), .Scalc_done_in(Scalc_done_in),
    .synd_out(synd_out), .synd_valid_out(synd_valid_out),
    .frame_clean_out(frame_clean_out), .kes_start_out(kes_start_out),
    .kes_ready_in(kes_ready_in), .abort_out(abort_out), .overrun_out(overrun_out),
    .stat_total_out(stat_total_out), .stat_err_out(stat_err_out)
  );

  int checks = 0, errors = 0;
  int exp_total = 0, exp_err = 0;
  logic [7:0] apow [N];
  logic [7:0] fr [N];
  logic [7:0] exp_s [2*NS];

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = 8'h00; aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1d) : (aa << 1);
    end
    return p;
  endfunction

  // SyndromeCalc stand-in: sync is registered inside it, so data counts from the
  // cycle after sync is seen low; S_j = sum r_i * alpha^(j*i), first symbol i=0.
  logic       sync_prev = 1'b1;
  int         pos = 0, eidx = -1;
  logic [7:0] acc [NS] = '{default: 8'h00};
  logic [7:0] ebuf [NS] = '{default: 8'h00};

  always @(negedge clk_in) begin
    if (eidx >= 0) begin
      Syndrome_in   = ebuf[eidx];
      Scalc_done_in = (eidx == 0);
      eidx          = (eidx == NS - 1) ? -1 : eidx + 1;
    end else begin
      Syndrome_in   = 8'h00;
      Scalc_done_in = 1'b0;
    end
    if (rst_in || sync_prev !== 1'b0) begin
      pos = 0;
      for (int j = 0; j < NS; j++) acc[j] = 8'h00;
      if (rst_in) eidx = -1;
    end else begin
      for (int j = 0; j < NS; j++) acc[j] = acc[j] ^ gf_mul(sc_data_out, apow[((j + 1) * pos) % N]);
      pos++;
      if (pos == N) begin
        ebuf = acc;
        eidx = 0;
        pos  = 0;
        for (int j = 0; j < NS; j++) acc[j] = 8'h00;
      end
    end
    sync_prev = sync_out;
  end

  int n_clean = 0, n_kes = 0, n_kes_al = 0, n_abort = 0, n_sv = 0;
  int cyc = 0, kes_t0 = 0, kes_t1 = 0, low_run = 0, last_low = 0;
  logic sv_prev = 1'b0;
  logic [7:0] rep_q [$];

  always @(negedge clk_in) begin
    cyc++;
    if (!rst_in) begin
      if (frame_clean_out) n_clean++;
      if (kes_start_out) begin
        n_kes++;
        kes_t0 = kes_t1;
        kes_t1 = cyc;
        if (synd_valid_out && !sv_prev) n_kes_al++;
      end
      if (abort_out) n_abort++;
      if (synd_valid_out) begin
        n_sv++;
        rep_q.push_back(synd_out);
      end
      if (sync_out == 1'b0) low_run++;
      else begin
        if (low_run > 0) last_low = low_run;
        low_run = 0;
      end
    end
    sv_prev = synd_valid_out;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc_drive(input logic v, input logic s, input logic [7:0] d);
    valid_in = v; sof_in = s; data_in = d;
    @(posedge clk_in); #1;
  endtask

  task automatic idle(input int k);
    repeat (k) cyc_drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_frame();
    for (int i = 0; i < N; i++) cyc_drive(1'b1, i == 0, fr[i]);
  endtask

  // kind 0: all zero, 1: random symbols, 2: one random error at a random position
  task automatic gen_frame(input int kind);
    for (int i = 0; i < N; i++) fr[i] = (kind == 1) ? 8'($urandom) : 8'h00;
    if (kind == 2) fr[$urandom_range(0, N - 1)] = 8'($urandom_range(1, 255));
  endtask

  task automatic ref_synd(input int off);
    for (int j = 0; j < NS; j++) begin
      exp_s[off + j] = 8'h00;
      for (int i = 0; i < N; i++)
        if (fr[i] != 8'h00) exp_s[off + j] = exp_s[off + j] ^ gf_mul(fr[i], apow[((j + 1) * i) % N]);
    end
  endtask

  function automatic bit exp_nz(input int off);
    bit r = 1'b0;
    for (int j = 0; j < NS; j++) r = r | (exp_s[off + j] != 8'h00);
    return r;
  endfunction

  task automatic run_frame(input string tag, input int kind);
    int c0, k0, a0, s0, b;
    bit nz;
    gen_frame(kind);
    ref_synd(0);
    nz = exp_nz(0);
    c0 = n_clean; k0 = n_kes; a0 = n_kes_al; s0 = n_sv; b = rep_q.size();
    send_frame();
    idle(80);
    chk({tag, "_clean"}, n_clean - c0, nz ? 0 : 1);
    chk({tag, "_kes"}, n_kes - k0, nz ? 1 : 0);
    chk({tag, "_kes_align"}, n_kes_al - a0, nz ? 1 : 0);
    chk({tag, "_nvalid"}, n_sv - s0, nz ? NS : 0);
    chk({tag, "_sync_low"}, last_low, N);
    if (nz && rep_q.size() >= b + NS)
      for (int j = 0; j < NS; j++) chk({tag, "_replay"}, rep_q[b + j], exp_s[j]);
    exp_total++;
    if (nz) exp_err++;
  endtask

  task automatic chk_stats(input string tag);
    int et, ee;
`ifdef RS_FRAME_STATS_EN
    et = exp_total; ee = exp_err;
`else
    et = 0; ee = 0;
`endif
    chk({tag, "_stat_total"}, stat_total_out, et);
    chk({tag, "_stat_err"}, stat_err_out, ee);
  endtask

  initial begin
    int c0, k0, s0, a0, b;
    bit nza, nzb;
    apow[0] = 8'h01;
    for (int i = 1; i < N; i++) apow[i] = gf_mul(apow[i - 1], 8'h02);

    // reset state, with live data on the input to expose the delay line
    rst_in = 1'b1; data_in = 8'ha5; valid_in = 1'b1; sof_in = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_sync", sync_out, 1'b1);
    chk("rst_scdata", sc_data_out, 8'h00);
    chk("rst_valid", synd_valid_out, 1'b0);
    chk("rst_clean", frame_clean_out, 1'b0);
    chk("rst_kes", kes_start_out, 1'b0);
    chk("rst_abort", abort_out, 1'b0);
    chk("rst_overrun", overrun_out, 1'b0);
    chk_stats("rst");
    rst_in = 1'b0;
    idle(3);

    // sof without valid is ignored
    cyc_drive(1'b0, 1'b1, 8'h00);
    idle(1);
    chk("sof_novalid_sync", sync_out, 1'b1);

    // sc_data_out is data_in delayed by two registers
    cyc_drive(1'b0, 1'b0, 8'h3c);
    cyc_drive(1'b0, 1'b0, 8'hc3);
    chk("delay2_a", sc_data_out, 8'h3c);
    cyc_drive(1'b0, 1'b0, 8'h00);
    chk("delay2_b", sc_data_out, 8'hc3);
    idle(3);

    run_frame("zero", 0);
    for (int i = 0; i < N; i++) fr[i] = 8'h00;
    fr[0] = 8'h01;
    ref_synd(0);
    c0 = n_kes; b = rep_q.size();
    send_frame();
    idle(80);
    chk("single_kes", n_kes - c0, 1);
    if (rep_q.size() >= b + NS)
      for (int j = 0; j < NS; j++) chk("single_replay", rep_q[b + j], 8'h01);
    exp_total++; exp_err++;

    for (int r = 0; r < 4; r++) run_frame("rand", int'($urandom_range(0, 2)));

    // back-to-back corrupted frames
    c0 = n_kes; s0 = n_sv; a0 = n_kes_al; b = rep_q.size();
    gen_frame(1); ref_synd(0); nza = exp_nz(0);
    send_frame();
    gen_frame(1); ref_synd(NS); nzb = exp_nz(NS);
    send_frame();
    idle(80);
    chk("b2b_kes", n_kes - c0, int'(nza) + int'(nzb));
    chk("b2b_align", n_kes_al - a0, int'(nza) + int'(nzb));
    chk("b2b_sync_low", last_low, 2 * N);
    if (nza && nzb) chk("b2b_gap", kes_t1 - kes_t0, N);
    chk("b2b_nvalid", n_sv - s0, NS * (int'(nza) + int'(nzb)));
    if (nza && nzb && rep_q.size() >= b + 2 * NS)
      for (int j = 0; j < 2 * NS; j++) chk("b2b_replay", rep_q[b + j], exp_s[j]);
    exp_total += 2; exp_err += int'(nza) + int'(nzb);

    // valid gap at symbol 100
    gen_frame(1);
    c0 = n_clean; k0 = n_kes; a0 = n_abort; s0 = n_sv;
    for (int i = 0; i < 100; i++) cyc_drive(1'b1, i == 0, fr[i]);
    cyc_drive(1'b0, 1'b0, 8'h00);
    chk("abort_pulse", abort_out, 1'b1);
    chk("abort_sync", sync_out, 1'b1);
    idle(1);
    chk("abort_oneshot", abort_out, 1'b0);
    idle(300);
    chk("abort_count", n_abort - a0, 1);
    chk("abort_no_clean", n_clean - c0, 0);
    chk("abort_no_kes", n_kes - k0, 0);
    chk("abort_no_valid", n_sv - s0, 0);
    chk("pre_overrun", overrun_out, 1'b0);

    // KES busy at decision
    kes_ready_in = 1'b0;
    gen_frame(1); ref_synd(0); nza = exp_nz(0);
    k0 = n_kes; s0 = n_sv;
    send_frame();
    idle(80);
    chk("ovr_set", overrun_out, nza);
    chk("ovr_no_kes", n_kes - k0, 0);
    chk("ovr_no_replay", n_sv - s0, 0);
    exp_total++; if (nza) exp_err++;
    kes_ready_in = 1'b1;
    run_frame("post_ovr", 0);
    chk("ovr_sticky", overrun_out, nza);
    chk_stats("end");

    // reset mid-frame discards everything
    for (int i = 0; i < 50; i++) cyc_drive(1'b1, i == 0, 8'($urandom));
    rst_in = 1'b1;
    cyc_drive(1'b1, 1'b0, 8'h77);
    chk("mrst_sync", sync_out, 1'b1);
    chk("mrst_scdata", sc_data_out, 8'h00);
    chk("mrst_overrun", overrun_out, 1'b0);
    exp_total = 0; exp_err = 0;
    chk_stats("mrst");
    rst_in = 1'b0;
    idle(5);
    run_frame("after_rst", 0);
    chk_stats("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rs_syndrome_ctrl.md
Name: rs_syndrome_ctrl

Overview:
Frame-level sequencer in front of SyndromeCalc. It accepts the upstream symbol stream with start and valid qualifiers, drives SyndromeCalc's sync and data inputs with exact alignment, and collects the 2t serial syndromes. It zero-detects the syndromes and either flags the frame clean or hands it to the key-equation solver (KES) with a start/ready handshake. It sits between the receive interface and the KES/Chien stages.

Parameters:
n, 255, frame length in symbols
k, 239, message symbols per frame
t, 8, correctable symbols; 2t syndromes per frame
m, 8, symbol width
STAT_W, 16, statistics counter width (RS_FRAME_STATS_EN only)

Ports:
clk_in  in  1  system clock, 125 MHz
rst_in  in  1  synchronous, active-high reset
data_in  in  m  received symbol
valid_in  in  1  symbol qualifier; must stay high for n contiguous cycles per frame
sof_in  in  1  start of frame, coincident with the first valid symbol
sync_out  out  1  to SyndromeCalc sync; high means hold/initialise
sc_data_out  out  m  to SyndromeCalc data_in
Syndrome_in  in  m  from SyndromeCalc Syndrome_out
Scalc_done_in  in  1  from SyndromeCalc Scalc_done
synd_out  out  m  captured syndrome, S1 first
synd_valid_out  out  1  qualifies synd_out, 2t consecutive cycles
frame_clean_out  out  1  1-cycle pulse: all 2t syndromes zero
kes_start_out  out  1  1-cycle pulse: start KES on the buffered syndromes
kes_ready_in  in  1  KES idle and able to accept a start
abort_out  out  1  1-cycle pulse: frame dropped (valid gap)
overrun_out  out  1  sticky: KES not ready at hand-off; cleared by reset only
stat_total_out  out  STAT_W  frames completed (macro only)
stat_err_out  out  STAT_W  frames with non-zero syndrome (macro only)

Behaviour:
- Reset values: sync_out=1, sc_data_out=0, and all pulses, valids, overrun_out and stats = 0. State is IDLE.
- Ingress FSM states:
  - IDLE: sync_out=1. On valid_in & sof_in, go to RUN and clear the symbol counter. sof_in without valid_in is ignored.
  - RUN: sync_out=0 starting the cycle after sof is accepted. Count accepted symbols 1..n.
  - At count n with valid_in & sof_in on the next cycle: stay in RUN (back-to-back) and keep sync_out low. SyndromeCalc wraps internally.
  - At count n otherwise: go to IDLE, sync_out=1.
- Data alignment:
  - sc_data_out is data_in delayed by exactly 2 registers.
  - Symbol 0 appears on sc_data_out one cycle after sync_out first falls.
- Abort conditions in RUN:
  - valid_in=0 mid-frame: pulse abort_out, force sync_out=1 for at least 1 cycle, go to IDLE, suppress collection for that frame.
  - sof_in mid-frame: treated as an abort, then the new sof is accepted in the following cycle.
- Collector:
  - On Scalc_done_in=1, capture Syndrome_in on that cycle as S1 and on the next 2t-1 cycles as S2..S2t.
  - Store the syndromes in a 2t x m buffer and OR-reduce them into a nonzero flag.
  - Replay: synd_out/synd_valid_out stream S1..S2t starting the cycle after the last capture. The replay is skipped when clean.
- Decision, made on the cycle after the last capture:
  - nonzero=0: pulse frame_clean_out.
  - nonzero=1 and kes_ready_in=1: pulse kes_start_out, aligned with the first replayed syndrome.
  - nonzero=1 and kes_ready_in=0: set overrun_out, drop the frame, no replay.
- Scalc_done_in while a collection is in progress is ignored; it cannot occur with legal n-spaced frames.
- rst_in mid-frame: everything returns to reset values next cycle; partial buffers are discarded.

Optional Feature:
- Macro: RS_FRAME_STATS_EN.
- Defined:
  - stat_total_out increments per completed collection.
  - stat_err_out increments per nonzero frame.
  - Both saturate at all-ones and clear on rst_in.
- Undefined: both ports are tied to 0 and no counters are synthesised.

Decomposition:
- Package rs_pkg holds: n/k/t/m defaults, the ingress state enum (IDLE, RUN), the collector state enum (WAIT, CAPTURE, DECIDE, REPLAY), and the counter widths derived via $clog2(n+1) and $clog2(2t+1).
- One sub-module, rs_synd_collector, holds the capture buffer, zero-detect, replay and the KES handshake.

Test Plan:
- Single error-free frame (all-zero codeword, n=255) -> sync_out low 255 cycles; exactly one frame_clean_out pulse; no kes_start_out; synd_valid_out never high.
- Frame with data_in=0x01 at position 0 only -> kes_start_out pulse with kes_ready_in=1; 16 replayed syndromes all equal 0x01.
- Two back-to-back corrupted frames -> sync_out stays 0 across the boundary; two kes_start_out pulses 255 cycles apart.
- valid_in dropped at symbol 100 -> abort_out pulse; sync_out=1 next cycle; no frame_clean_out or kes_start_out for that frame.
- Corrupted frame with kes_ready_in=0 at decision -> overrun_out=1 and remains set; no replay.
- RS_FRAME_STATS_EN, 3 clean + 2 corrupted frames -> stat_total_out=5, stat_err_out=2; rst_in clears both.
